simplex_rx_initializer: RTL and testbench
=========================================

Name: simplex_rx_initializer

Overview:
- Receive-side partner of the transmit channel initialization state machine.
- Watches the decoded ordered-set stream arriving from the link partner (SP, then I, then VER).
- Produces the simplex_aligned / simplex_bonded / simplex_verified / simplex_reset status that the transmit-side initializer consumes over the simplex sideband.
- Sits between the lane RX decoder and the TX channel initializer; also reports rx_ready to the RX datapath.

Parameters:
- SP_COUNT, 4: consecutive SP sets required to declare alignment; also to detect a partner restart in READY.
- BOND_COUNT, 4: consecutive I sets required to declare bonding (multi-lane only).
- VER_COUNT, 8: consecutive VER sets required to declare verification.
- TIMEOUT, 1024: watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- single_lane  input  1  1 = skip bonding; sampled every cycle.
- rx_valid  input  1  rx_ordered_set is valid this cycle.
- rx_ordered_set  input  ordered_sets_e (aurora_pkg)  decoded received set: NONE/SP/I/VER.
- simplex_aligned  output  1  level; partner SP stream qualified.
- simplex_bonded  output  1  level; partner I stream qualified, or single-lane.
- simplex_verified  output  1  level; partner VER stream qualified.
- simplex_reset  output  1  one-cycle pulse requesting re-initialization of TX initializer.
- rx_ready  output  1  level; RX side fully initialized.

Behaviour:
- All outputs registered. Reset (rst_n=0 at clk edge): state=RESET, all counters 0, all outputs 0.
- States: RESET, WAIT_ALIGN, WAIT_BOND, WAIT_VER, READY. RESET -> WAIT_ALIGN unconditionally after one cycle.
- Counting rule for all states:
  - Cycles with rx_valid=0 hold the counter.
  - rx_valid=1 with the expected set increments the counter (saturating at its target).
  - rx_valid=1 with any other set clears the counter to 0.
  - Counter width is $clog2(max(SP_COUNT,BOND_COUNT,VER_COUNT)+1).
- WAIT_ALIGN (expects SP):
  - On the cycle the SP_COUNT-th consecutive SP is accepted, the counter clears and the state moves to WAIT_BOND, or to WAIT_VER if single_lane=1.
  - simplex_aligned=1 from the next cycle.
  - If single_lane=1, simplex_bonded also =1 from the same cycle.
- WAIT_BOND (expects I):
  - On the BOND_COUNT-th consecutive I: simplex_bonded=1 next cycle, state -> WAIT_VER.
  - SP received: counter clears, no state change.
- WAIT_VER (expects VER):
  - On the VER_COUNT-th consecutive VER: simplex_verified=1 and rx_ready=1 next cycle, state -> READY.
- READY:
  - Outputs held.
  - Counts consecutive SP; I/VER/NONE clear the count.
  - SP_COUNT consecutive SP means partner restart: simplex_reset=1 for exactly one cycle, and that same cycle all other outputs and counters clear and state=RESET.
- Once set, aligned/bonded/verified stay 1 until rst_n=0 or a simplex_reset pulse.
- simplex_reset is never asserted outside the READY restart path, except via the optional feature.
- rst_n=0 mid-operation overrides everything, including a pending simplex_reset pulse, which is suppressed.
- single_lane changing while in WAIT_BOND/WAIT_VER is ignored; it is only consulted on the WAIT_ALIGN exit.
- Latency: qualifying set accepted at edge N -> status bit visible after edge N+1.

Optional Feature:
- Macro: SIMPLEX_RX_WATCHDOG_EN.
- Defined:
  - A cycle counter of $clog2(TIMEOUT+1) bits runs in WAIT_ALIGN/WAIT_BOND/WAIT_VER.
  - It clears on every state change and is inactive in RESET and READY.
  - When it reaches TIMEOUT: simplex_reset pulses for one cycle, all outputs clear, state=RESET.
- Undefined: no watchdog logic; the block waits indefinitely in any state.

Test Plan:
- Reset, single_lane=0, then 4 SP, 4 I, 8 VER (rx_valid=1 throughout) -> aligned rises 1 cycle after 4th SP, bonded 1 cycle after 4th I, verified and rx_ready 1 cycle after 8th VER; simplex_reset stays 0.
- single_lane=1, 4 SP then 8 VER -> aligned and bonded rise together 1 cycle after 4th SP; no I needed; rx_ready after 8th VER.
- WAIT_VER: 5 VER, 1 I, 8 VER -> verified rises only after the 8 VER following the I. Separately, rx_valid=0 gaps inside the VER run -> count held, verified after 8 valid VER.
- READY: 3 SP, 1 NONE, 4 SP -> no reset after the first 3; simplex_reset one-cycle pulse after the 4th consecutive SP, and all status outputs 0 the same cycle.
- rst_n=0 for 1 cycle while in WAIT_BOND with count=3 -> all outputs 0 and state RESET; the sequence then restarts from SP.
- With SIMPLEX_RX_WATCHDOG_EN and TIMEOUT=16: hold rx_ordered_set=NONE in WAIT_ALIGN -> simplex_reset pulse on cycle 16. Without the macro -> no pulse after 100 cycles.

Source files
------------

// File: rtl/simplex_rx_initializer.sv
// rtl/simplex_rx_initializer.sv - receive-side simplex initializer: qualifies partner SP/I/VER runs into status bits
// Optional watchdog enabled by defining SIMPLEX_RX_WATCHDOG_EN.
package aurora_pkg;
  typedef enum logic [1:0] {
    NONE = 2'd0,
    SP   = 2'd1,
    I    = 2'd2,
    VER  = 2'd3
  } ordered_sets_e;
endpackage

module simplex_rx_initializer
  import aurora_pkg::*;
#(
  parameter int SP_COUNT   = 4,
  parameter int BOND_COUNT = 4,
  parameter int VER_COUNT  = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          single_lane,
  input  logic          rx_valid,
  input  ordered_sets_e rx_ordered_set,
  output logic          simplex_aligned,
  output logic          simplex_bonded,
  output logic          simplex_verified,
  output logic          simplex_reset,
  output logic          rx_ready
);

  localparam int MAX_AB    = (SP_COUNT > BOND_COUNT) ? SP_COUNT : BOND_COUNT;
  localparam int MAX_COUNT = (MAX_AB > VER_COUNT) ? MAX_AB : VER_COUNT;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  if (SP_COUNT < 1 || BOND_COUNT < 1 || VER_COUNT < 1 || TIMEOUT < 1) begin : g_param_check
    $error("simplex_rx_initializer: SP_COUNT, BOND_COUNT, VER_COUNT and TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    RESET      = 3'd0,
    WAIT_ALIGN = 3'd1,
    WAIT_BOND  = 3'd2,
    WAIT_VER   = 3'd3,
    READY      = 3'd4
  } state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] target;
  ordered_sets_e expected;
  logic          hit;
  logic          miss;
  logic          done;
  logic          wd_expire;

  // READY watches for a partner restart, which shows up as a fresh SP run.
  always_comb begin
    expected = SP;
    target   = CW'(SP_COUNT);
    case (state)
      WAIT_BOND: begin
        expected = I;
        target   = CW'(BOND_COUNT);
      end
      WAIT_VER: begin
        expected = VER;
        target   = CW'(VER_COUNT);
      end
      default: ;
    endcase
  end

  assign cnt_inc = cnt + 1'b1;
  assign hit     = rx_valid && (rx_ordered_set == expected);
  assign miss    = rx_valid && !hit;
  assign done    = hit && (cnt_inc == target);

`ifdef SIMPLEX_RX_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;
  logic          waiting;

  assign waiting   = (state == WAIT_ALIGN) || (state == WAIT_BOND) || (state == WAIT_VER);
  assign wd_expire = waiting && (wd == WW'(TIMEOUT - 1));

  // Any state change (a qualified run or an expiry) restarts the timeout window.
  always_ff @(posedge clk) begin
    if (!rst_n || !waiting || done || wd_expire) begin
      wd <= '0;
    end else begin
      wd <= wd + 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= RESET;
      cnt              <= '0;
      simplex_aligned  <= 1'b0;
      simplex_bonded   <= 1'b0;
      simplex_verified <= 1'b0;
      simplex_reset    <= 1'b0;
      rx_ready         <= 1'b0;
    end else begin
      simplex_reset <= 1'b0;
      if (done || miss) begin
        cnt <= '0;
      end else if (hit) begin
        cnt <= cnt_inc;
      end

      if (wd_expire) begin
        state            <= RESET;
        cnt              <= '0;
        simplex_aligned  <= 1'b0;
        simplex_bonded   <= 1'b0;
        simplex_verified <= 1'b0;
        simplex_reset    <= 1'b1;
        rx_ready         <= 1'b0;
      end else begin
        case (state)
          RESET: begin
            cnt   <= '0;
            state <= WAIT_ALIGN;
          end
          WAIT_ALIGN: begin
            if (done) begin
              simplex_aligned <= 1'b1;
              if (single_lane) begin
                simplex_bonded <= 1'b1;
                state          <= WAIT_VER;
              end else begin
                state <= WAIT_BOND;
              end
            end
          end
          WAIT_BOND: begin
            if (done) begin
              simplex_bonded <= 1'b1;
              state          <= WAIT_VER;
            end
          end
          WAIT_VER: begin
            if (done) begin
              simplex_verified <= 1'b1;
              rx_ready         <= 1'b1;
              state            <= READY;
            end
          end
          READY: begin
            if (done) begin
              simplex_reset    <= 1'b1;
              simplex_aligned  <= 1'b0;
              simplex_bonded   <= 1'b0;
              simplex_verified <= 1'b0;
              rx_ready         <= 1'b0;
              state            <= RESET;
            end
          end
          default: begin
            cnt   <= '0;
            state <= RESET;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simplex_rx_initializer.sv
// tb/tb_simplex_rx_initializer.sv - self-checking bench for simplex_rx_initializer
// Vector table with expected outputs queued at drive time, plus watchdog sequences.
module tb_simplex_rx_initializer;
  import aurora_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          single_lane = 1'b0;
  logic          rx_valid = 1'b0;
  ordered_sets_e rx_ordered_set = NONE;
  logic          simplex_aligned;
  logic          simplex_bonded;
  logic          simplex_verified;
  logic          simplex_reset;
  logic          rx_ready;

  simplex_rx_initializer #(
    .SP_COUNT  (4),
    .BOND_COUNT(4),
    .VER_COUNT (8),
    .TIMEOUT   (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .single_lane     (single_lane),
    .rx_valid        (rx_valid),
    .rx_ordered_set  (rx_ordered_set),
    .simplex_aligned (simplex_aligned),
    .simplex_bonded  (simplex_bonded),
    .simplex_verified(simplex_verified),
    .simplex_reset   (simplex_reset),
    .rx_ready        (rx_ready)
  );

  always #5 clk = ~clk;

  // Output vector order: {aligned, bonded, verified, reset, rx_ready}
  localparam logic [4:0] Z   = 5'b00000;
  localparam logic [4:0] AL  = 5'b10000;
  localparam logic [4:0] AB  = 5'b11000;
  localparam logic [4:0] RDY = 5'b11101;
  localparam logic [4:0] RST = 5'b00010;

  typedef struct {
    logic          rst;
    logic          sl;
    logic          valid;
    ordered_sets_e os;
    logic [4:0]    exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;

  wire [4:0] outs = {simplex_aligned, simplex_bonded, simplex_verified, simplex_reset, rx_ready};

  function automatic void add(input logic r, input logic s, input logic v,
                              input ordered_sets_e os, input logic [4:0] e, input int n);
    vec_t t;
    t.rst = r; t.sl = s; t.valid = v; t.os = os; t.exp = e;
    for (int k = 0; k < n; k++) vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input ordered_sets_e os);
    @(negedge clk);
    rst_n = r; single_lane = s; rx_valid = v; rx_ordered_set = os;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [4:0] e;
    int first, second, pulses;

    // Multi-lane bring-up, then partner restart from READY
    add(0, 0, 0, NONE, Z, 2);
    add(1, 0, 0, NONE, Z, 1);
    add(1, 0, 1, SP,   Z, 3);  add(1, 0, 1, SP,  AL, 1);
    add(1, 0, 1, I,   AL, 3);  add(1, 0, 1, I,   AB, 1);
    add(1, 0, 1, VER, AB, 7);  add(1, 0, 1, VER, RDY, 1);
    add(1, 0, 1, SP, RDY, 3);  add(1, 0, 1, NONE, RDY, 1);
    add(1, 0, 1, SP, RDY, 3);  add(1, 0, 1, SP,  RST, 1);
    add(1, 0, 0, NONE, Z, 1);
    // Single lane, VER run broken by an I
    add(1, 1, 1, SP,   Z, 3);  add(1, 1, 1, SP,  AB, 1);
    add(1, 1, 1, VER, AB, 5);  add(1, 1, 1, I,   AB, 1);
    add(1, 1, 1, VER, AB, 7);  add(1, 1, 1, VER, RDY, 1);
    add(0, 1, 0, NONE, Z, 1);  add(1, 0, 0, NONE, Z, 1);
    // Reset in WAIT_BOND with count 3, restart from SP
    add(1, 0, 1, SP,   Z, 3);  add(1, 0, 1, SP,  AL, 1);
    add(1, 0, 1, I,   AL, 3);  add(0, 0, 1, I,   Z, 1);
    add(1, 0, 0, NONE, Z, 1);  add(1, 0, 1, I,   Z, 1);
    add(1, 0, 1, SP,   Z, 3);  add(1, 0, 1, SP,  AL, 1);
    // WAIT_BOND: SP clears count, single_lane flip ignored, invalid cycles hold
    add(1, 1, 1, I,   AL, 2);  add(1, 1, 1, SP,  AL, 1);
    add(1, 1, 0, I,   AL, 1);  add(1, 1, 1, I,   AL, 3);
    add(1, 1, 1, I,   AB, 1);
    // WAIT_VER with rx_valid=0 gaps (invalid non-VER must not clear)
    add(1, 0, 1, VER, AB, 1);  add(1, 0, 0, I,   AB, 1);
    add(1, 0, 1, VER, AB, 3);  add(1, 0, 0, NONE, AB, 2);
    add(1, 0, 1, VER, AB, 3);  add(1, 0, 0, VER, AB, 1);
    add(1, 0, 1, VER, RDY, 1);
    // rst_n on the restart edge suppresses the pulse
    add(1, 0, 1, SP, RDY, 3);  add(0, 0, 1, SP,  Z, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst_n = vecs[k].rst; single_lane = vecs[k].sl;
      rx_valid = vecs[k].valid; rx_ordered_set = vecs[k].os;
      exp_q.push_back(vecs[k].exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check($sformatf("scoreboard_empty_%0d", k), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d", k), {27'd0, outs}, {27'd0, e});
      end
    end
    check("scoreboard_drained", exp_q.size(), 0);

    drive(0, 0, 0, NONE);
    drive(1, 0, 0, NONE);
    first = -1; second = -1; pulses = 0;
`ifdef SIMPLEX_RX_WATCHDOG_EN
    for (int c = 1; c <= 40; c++) begin
      drive(1, 0, 1, NONE);
      if (simplex_reset === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
        check($sformatf("wd_clear_%0d", c), {27'd0, outs}, {27'd0, RST});
      end
    end
    check("wd_first_pulse_cycle", first, 16);
    check("wd_second_pulse_cycle", second, 33);
    check("wd_pulse_count", pulses, 2);
`else
    for (int c = 1; c <= 100; c++) begin
      drive(1, 0, 1, NONE);
      if (simplex_reset !== 1'b0) pulses++;
    end
    check("no_wd_pulse_count", pulses, 0);
    check("no_wd_outputs", {27'd0, outs}, {27'd0, Z});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
